// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive path.
//   N_CH    : channels per frame (fixed at 8 in this revision)
//   SEL_W   : channel index width, clog2(N_CH)
//   state_t : framing state of the receiver, HUNT or LOCKED
package tdm_pkg;

   localparam int N_CH  = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/demux1x8_en.sv
// Combinational 1-to-8 write-enable decoder built from 1-to-2 cells.
//   demux1x2 ports:
//     din   in   1      value to steer
//     sel   in   1      0 -> out0, 1 -> out1
//     out0  out  1
//     out1  out  1
//   demux1x8_en ports:
//     sel   in   SEL_W  channel index
//     en    in   1      global enable
//     we    out  N_CH   one-hot enable for channel sel, all zero when en=0
module demux1x2 (
   input  logic din,
   input  logic sel,
   output logic out0,
   output logic out1
);

   assign out0 = din & ~sel;
   assign out1 = din &  sel;

endmodule

module demux1x8_en
   import tdm_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [N_CH-1:0]  we
);

   logic [1:0] lvl1;
   logic [3:0] lvl2;

   // The MSB splits first, so each level's output index equals the
   // select bits consumed so far; the leaves line up with we[sel].
   demux1x2 u_root (
      .din  (en),
      .sel  (sel[2]),
      .out0 (lvl1[0]),
      .out1 (lvl1[1])
   );

   for (genvar i = 0; i < 2; i++) begin : g_lvl2
      demux1x2 u_mid (
         .din  (lvl1[i]),
         .sel  (sel[1]),
         .out0 (lvl2[2*i]),
         .out1 (lvl2[2*i+1])
      );
   end

   for (genvar j = 0; j < 4; j++) begin : g_lvl3
      demux1x2 u_leaf (
         .din  (lvl2[j]),
         .sel  (sel[0]),
         .out0 (we[2*j]),
         .out1 (we[2*j+1])
      );
   end

endmodule

// File: rtl/tdm_demux1x8.sv
// Time-division demultiplexer, receive side of the 8:1 channel-select path.
// Collects one sample per valid cycle into channel slots, aligned by in_sync
// on channel 0, and publishes each complete frame in parallel.
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   in_data      in   W         serial sample for the current slot
//   in_valid     in   1         sample valid; low stalls without advancing
//   in_sync      in   1         marks in_data as channel 0 (only when valid)
//   y_frame      out  N_CH*W    last complete frame, channel k at [k*W +: W]
//   frame_valid  out  1         one-cycle pulse when y_frame updates
//   ch_sel       out  SEL_W     slot the next accepted sample writes to
//   locked       out  1         receiver is frame-aligned
//   sync_err     out  1         one-cycle pulse on a framing error
module tdm_demux1x8
   import tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [W-1:0]        in_data,
   input  logic                in_valid,
   input  logic                in_sync,
   output logic [N_CH*W-1:0]   y_frame,
   output logic                frame_valid,
   output logic [SEL_W-1:0]    ch_sel,
   output logic                locked,
   output logic                sync_err
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   state_t             state;
   logic [W-1:0]       shadow [N_CH-1];
   logic [SEL_W-1:0]   wr_sel;
   logic               wr_en;
   logic [N_CH-1:0]    we;
   logic [N_CH*W-1:0]  frame_next;

   // A sync sample always lands in slot 0, whatever the counter says. Other
   // samples are written only while aligned past slot 0; a non-sync sample at
   // slot 0 (or while hunting) is a dropped sample, not a write.
   assign wr_sel = in_sync ? '0 : ch_sel;
   assign wr_en  = in_valid & (in_sync | ((state == LOCKED) && (ch_sel != '0)));

   demux1x8_en u_dec (
      .sel (wr_sel),
      .en  (wr_en),
      .we  (we)
   );

   // The channel-7 sample goes straight into the published frame, so only
   // slots 0..6 need shadow storage.
   always_comb begin
      frame_next = '0;
      for (int k = 0; k < N_CH - 1; k++) begin
         frame_next[k*W +: W] = shadow[k];
      end
      frame_next[(N_CH-1)*W +: W] = in_data;
   end

   // Shadow slots; never cleared after a discarded frame because every slot
   // is rewritten before the next publish can happen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_CH - 1; k++) begin
            shadow[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH - 1; k++) begin
            if (we[k]) begin
               shadow[k] <= in_data;
            end
         end
      end
   end

   // Framing FSM with slot counter, publish register and pulse outputs.
   // we[N_CH-1] is asserted exactly for an aligned, non-sync channel-7 sample,
   // which is the publish condition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         ch_sel      <= '0;
         y_frame     <= '0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (in_valid) begin
            case (state)
               HUNT: begin
                  if (in_sync) begin
                     ch_sel <= SEL_W'(1);
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (in_sync) begin
                     if (ch_sel != '0) begin
                        sync_err <= 1'b1;
                     end
                     ch_sel <= SEL_W'(1);
                  end else if (ch_sel == '0) begin
                     sync_err <= 1'b1;
                     state    <= HUNT;
                     locked   <= 1'b0;
                  end else if (we[N_CH-1]) begin
                     y_frame     <= frame_next;
                     frame_valid <= 1'b1;
                     ch_sel      <= '0;
                  end else begin
                     ch_sel <= ch_sel + SEL_W'(1);
                  end
               end
               default: begin
                  state  <= HUNT;
                  ch_sel <= '0;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

   // LAST_CH documents the counter's upper bound; the decoder output already
   // encodes the comparison.
   logic unused_ok;
   assign unused_ok = &{1'b0, LAST_CH};

endmodule
